// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared state encoding, width helper and constants for the
// time-multiplexed FIR sequencer.
package fir_seq_pkg;

    // FSM state encoding
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StMac  = 1'b1;

    // Coefficient 0 resets to +1 so the filter starts as a pass-through
    localparam int RstCoef0 = 1;

    // Default output clamp bounds (YW = 3)
    localparam int YMinDefault = -4;
    localparam int YMaxDefault = 3;

    // Accumulator width: wide enough that TAPS full-scale products never overflow
    function automatic int unsigned acc_width(int unsigned xw, int unsigned cw,
                                              int unsigned taps);
        return xw + cw + $clog2(taps);
    endfunction

    function automatic int y_max(int unsigned yw);
        return (1 << (yw - 1)) - 1;
    endfunction

    function automatic int y_min(int unsigned yw);
        return -(1 << (yw - 1));
    endfunction

endpackage

// File: rtl/fir_seq_reduce.sv
// fir_seq_reduce: narrows the AW-bit accumulator to the YW-bit output.
// FIR_SEQ_SAT_EN defined: clamp to the signed YW range; otherwise plain
// two's-complement wrap (low YW bits).
module fir_seq_reduce
    import fir_seq_pkg::*;
#(
    parameter int unsigned AW = 6,
    parameter int unsigned YW = 3
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [YW-1:0] y
);

`ifdef FIR_SEQ_SAT_EN
    localparam logic signed [AW-1:0] Hi = AW'(y_max(YW));
    localparam logic signed [AW-1:0] Lo = AW'(y_min(YW));

    // Clamp out-of-range accumulator values to the nearest representable output
    always_comb begin
        if (acc > Hi) begin
            y = Hi[YW-1:0];
        end else if (acc < Lo) begin
            y = Lo[YW-1:0];
        end else begin
            y = acc[YW-1:0];
        end
    end
`else
    // Upper accumulator bits are discarded by design in wrap mode
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[AW-1:YW];

    // Two's-complement wrap: keep the low YW bits
    always_comb begin
        y = acc[YW-1:0];
    end
`endif

endmodule

// File: rtl/fir_seq.sv
// fir_seq: time-multiplexed FIR sequencer. One shared MAC walks the tap index
// across the delay line, one product per cycle, then emits a reduced result
// with a one-cycle out_valid pulse. Saturation is selected by FIR_SEQ_SAT_EN.
module fir_seq
    import fir_seq_pkg::*;
#(
    parameter int unsigned TAPS = 4,
    parameter int unsigned XW   = 2,
    parameter int unsigned CW   = 2,
    parameter int unsigned YW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XW-1:0]            x_in,
    input  logic                     cfg_we,
    input  logic [$clog2(TAPS)-1:0]  cfg_addr,
    input  logic [CW-1:0]            cfg_data,
    output logic                     out_valid,
    output logic [YW-1:0]            y_out,
    output logic                     busy
);

    localparam int unsigned AW = acc_width(XW, CW, TAPS);
    localparam int unsigned IW = $clog2(TAPS);

    logic [0:0]              state_q;
    logic [IW-1:0]           idx_q;
    logic signed [AW-1:0]    acc_q;
    logic signed [XW-1:0]    tap_q  [TAPS];
    logic signed [CW-1:0]    coef_q [TAPS];
    logic                    out_valid_q;
    logic [YW-1:0]           y_q;

    logic signed [AW-1:0]    tap_ext;
    logic signed [AW-1:0]    coef_ext;
    logic signed [AW-1:0]    prod;
    logic signed [AW-1:0]    sum;
    logic signed [YW-1:0]    y_red;
    logic                    last;

    // Single MAC: the coefficient is read in the product's own cycle, so a
    // cfg write to index k only matters if it lands before idx reaches k
    always_comb begin
        tap_ext  = AW'(tap_q[idx_q]);
        coef_ext = AW'(coef_q[idx_q]);
        prod     = tap_ext * coef_ext;
        sum      = acc_q + prod;
        last     = (state_q == StMac) && (idx_q == IW'(TAPS - 1));
    end

    fir_seq_reduce #(
        .AW (AW),
        .YW (YW)
    ) u_reduce (
        .acc (sum),
        .y   (y_red)
    );

    // FSM, tap index, accumulator, delay line and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == StIdle) begin
                if (in_valid) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        tap_q[i] <= tap_q[i-1];
                    end
                    tap_q[0] <= x_in;
                    acc_q    <= '0;
                    idx_q    <= '0;
                    state_q  <= StMac;
                end
            end else begin
                if (last) begin
                    // Final product goes straight into the result, not into acc
                    y_q         <= y_red;
                    out_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end else begin
                    acc_q <= sum;
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

    // Coefficient file: writable in any state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= (i == 0) ? CW'(RstCoef0) : '0;
            end
        end else if (cfg_we) begin
            coef_q[cfg_addr] <= cfg_data;
        end
    end

    // Status outputs come straight from registered state
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StMac);
        out_valid = out_valid_q;
        y_out     = y_q;
    end

endmodule

// File: doc/fir_seq.md
# fir_seq

Time-multiplexed FIR sequencer for the small-sample filter path. It shares one multiply-accumulate unit across all taps: it accepts a sample, walks the tap index over the delay line one product per cycle, and emits a saturated result with a valid pulse. Coefficients are runtime-writable through a register port. It sits between the `io_in` sample pins and the `io_out` result pins of the top level.

## Interface
- `TAPS`, 4: filter length; power of two, ≥2.
- `XW`, 2: sample width, signed two's complement.
- `CW`, 2: coefficient width, signed two's complement.
- `YW`, 3: output width, signed two's complement.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  block can accept a sample.
- `x_in`  in  XW  sample.
- `cfg_we`  in  1  coefficient write strobe.
- `cfg_addr`  in  clog2(TAPS)  coefficient index.
- `cfg_data`  in  CW  coefficient value.
- `out_valid`  out  1  one-cycle pulse, `y_out` updated.
- `y_out`  out  YW  filter result, held until next result.
- `busy`  out  1  high while in MAC.

## Operation
- Accumulator width AW = XW + CW + clog2(TAPS) (6 by default); all arithmetic is signed at AW, with no internal overflow.
- Delay line `tap[0..TAPS-1]`; `tap[0]` is the newest sample.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, shift the line (`tap[i]<=tap[i-1]`, `tap[0]<=x_in`), set acc<=0 and idx<=0, go to MAC.
  - MAC: `in_ready`=0, `busy`=1. Each cycle, acc += coef[idx]*tap[idx] and idx++. On idx==TAPS-1, do not update acc. Instead, `y_out` <= reduce(acc + last product), `out_valid`<=1, go to IDLE.
- `in_valid` while not ready is ignored; the sample is not captured and no error is raised.
- Coefficient writes are accepted in any state. A product uses the coefficient register value in its own cycle, so a write to index k during MAC affects this result only if it lands before the cycle where idx==k.
- `cfg_we` and sample acceptance in the same cycle are both performed.
- Reset values:
  - `in_ready`=1 (IDLE), `busy`=0, `out_valid`=0, `y_out`=0, acc=0, idx=0.
  - Delay line all 0.
  - coef[0]=1, other coefficients 0 (pass-through).
- `rst` during MAC aborts the sample: no `out_valid` pulse, and all state returns to reset values.

## Timing
- Acceptance edge E0. Products are computed at edges E1..E(TAPS).
- `out_valid`=1 and the new `y_out` are visible after E(TAPS), i.e. latency TAPS cycles.
- `in_ready` is high in the same cycle as `out_valid`. Back-to-back throughput is one sample per TAPS+1 cycles (5 by default).
- `in_ready`, `busy` and `out_valid` are driven from registered state. `in_ready` = (state==IDLE).

## Configuration
- `FIR_SEQ_SAT_EN` defined: reduce() clamps acc to [-2^(YW-1), 2^(YW-1)-1], i.e. [-4, 3] by default.
- Not defined: reduce() takes acc[YW-1:0] (two's-complement wrap). There is no saturation logic.

## Structure
- `fir_seq_pkg` holds:
  - the state enum (IDLE, MAC);
  - the AW width function;
  - the reset coefficient constant;
  - the YW min/max constants.
- Sub-module `fir_seq_reduce` is combinational: AW in, YW out. It contains the `FIR_SEQ_SAT_EN` choice.
- Top level holds the FSM, idx counter, delay line, coefficient file and single MAC.

## Test plan
- Reset defaults: after `rst`, send x=1 → `out_valid` 4 cycles later with `y_out`=1. Then send x=-1 → `y_out`=-1, with no history contribution.
- All coefficients 1, samples 1,1,1,1 each accepted when ready → results 1,2,3,3 with SAT_EN; results 1,2,3,-4 without it.
- All coefficients -2, samples -2 ×4 → final acc 16: `y_out`=3 with SAT_EN, 0 without.
- `in_valid` held high continuously → exactly one acceptance per 5 cycles, and `in_ready` is low during `busy`.
- Reset asserted at the 2nd MAC cycle → no `out_valid`, `y_out`=0, delay line cleared. The next sample x=1 gives `y_out`=1.
- Write coef[3]=1 during the MAC cycle with idx=1, with tap[3]=1 and coef[0..2]=0 → `y_out`=1. The same write at idx==3 or later → `y_out`=0.
